// File: rtl/ysyx_22040931_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22040931_ifu_pkg;

   localparam int DATA_BUS = 64;
   localparam int ADDR_W   = DATA_BUS;
   localparam int INST_W   = 32;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_REQ  = 2'd1,
      IFU_WAIT = 2'd2,
      IFU_HOLD = 2'd3
   } ifu_state_t;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'd0,
      PC_INC   = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_t;

endpackage

// File: rtl/ysyx_22040931_pc_reg.sv
// Program counter register: holds, advances the fetched PC by 4, or loads a redirect target.
module ysyx_22040931_pc_reg
   import ysyx_22040931_ifu_pkg::*;
#(
   parameter int          W         = 64,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  pc_sel_t      sel,
   input  logic [W-1:0] base,
   input  logic [W-1:0] target,
   output logic [W-1:0] pc
);

   localparam logic [W-1:0] STEP = W'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VAL;
      end else begin
         case (sel)
            PC_INC:   pc <= base + STEP;
            PC_REDIR: pc <= target;
            default:  pc <= pc;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch unit with one outstanding imem request and redirect kill.
// Optional: YSYX_22040931_IFU_MISALIGN_EN rejects misaligned redirects and pulses misalign_exc.
module ysyx_22040931_ifu
   import ysyx_22040931_ifu_pkg::*;
#(
   parameter int                ADDR_W   = ysyx_22040931_ifu_pkg::ADDR_W,
   parameter int                INST_W   = ysyx_22040931_ifu_pkg::INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ysyx_22040931_ifu_pkg::RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_inst,
   output logic [ADDR_W-1:0] id_pc
`ifdef YSYX_22040931_IFU_MISALIGN_EN
  ,output logic              misalign_exc
`endif
);

   ifu_state_t        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic              kill;
   logic              redir;
   logic              req_hs;
   pc_sel_t           pc_sel;

`ifdef YSYX_22040931_IFU_MISALIGN_EN
   logic misaligned;
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redir      = redirect_valid && !misaligned;
`else
   assign redir      = redirect_valid;
`endif

   assign imem_req_valid = (state == IFU_REQ);
   assign imem_req_addr  = pc;
   // Any redirect, even a rejected misaligned one, blocks the decode transfer this cycle.
   assign id_valid       = (state == IFU_HOLD) && !redirect_valid;
   assign req_hs         = imem_req_valid && imem_req_ready;

   always_comb begin
      pc_sel = PC_HOLD;
      if (redir) begin
         pc_sel = PC_REDIR;
      end else if (state == IFU_WAIT && imem_rsp_valid && !kill) begin
         pc_sel = PC_INC;
      end
   end

   ysyx_22040931_pc_reg #(
      .W         (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (pc_sel),
      .base   (req_pc),
      .target (redirect_pc),
      .pc     (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IFU_IDLE;
         req_pc  <= '0;
         kill    <= 1'b0;
         id_inst <= '0;
         id_pc   <= '0;
      end else begin
         case (state)
            IFU_IDLE: state <= IFU_REQ;
            IFU_REQ: begin
               if (req_hs) begin
                  req_pc <= pc;
                  state  <= IFU_WAIT;
                  if (redir) kill <= 1'b1;
               end
            end
            IFU_WAIT: begin
               if (redir) begin
                  if (imem_rsp_valid) begin
                     kill  <= 1'b0;
                     state <= IFU_REQ;
                  end else begin
                     kill  <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= IFU_REQ;
                  end else begin
                     id_inst <= imem_rsp_data;
                     id_pc   <= req_pc;
                     state   <= IFU_HOLD;
                  end
               end
            end
            IFU_HOLD: begin
               if (redir || id_valid && id_ready) state <= IFU_REQ;
            end
            default: state <= IFU_IDLE;
         endcase
      end
   end

`ifdef YSYX_22040931_IFU_MISALIGN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_exc <= 1'b0;
      else        misalign_exc <= misaligned;
   end
`endif

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// Directed bench for the fetch unit: reset, fetch, stall, redirect kill paths, wrap.
module tb_ysyx_22040931_ifu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [63:0] id_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_22040931_ifu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      #12;
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_req_addr",  imem_req_addr, 64'h8000_0000);
      chk("rst_id_valid",  {63'd0, id_valid}, 64'd0);
      chk("rst_id_inst",   {32'd0, id_inst}, 64'd0);
      chk("rst_id_pc",     id_pc, 64'd0);
      tick();
      chk("rst_hold_valid", {63'd0, imem_req_valid}, 64'd0);
      rst_n = 1'b1;

      // first fetch
      tick();
      chk("req1_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("req1_addr",  imem_req_addr, 64'h8000_0000);
      tick();
      chk("wait1_valid", {63'd0, imem_req_valid}, 64'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("f1_id_valid", {63'd0, id_valid}, 64'd1);
      chk("f1_id_inst",  {32'd0, id_inst}, 64'h13);
      chk("f1_id_pc",    id_pc, 64'h8000_0000);
      chk("f1_next_addr", imem_req_addr, 64'h8000_0004);

      // decode stall
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_id_valid", {63'd0, id_valid}, 64'd1);
         chk("stall_id_inst",  {32'd0, id_inst}, 64'h13);
         chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      settle();
      chk("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rel_req_addr",  imem_req_addr, 64'h8000_0004);

      // redirect in WAIT without response, then killed response
      tick();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      settle();
      chk("rw_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rw_addr",      imem_req_addr, 64'h8000_0100);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("rw_id_valid",  {63'd0, id_valid}, 64'd0);
      chk("rw_req_valid2", {63'd0, imem_req_valid}, 64'd1);
      chk("rw_req_addr2", imem_req_addr, 64'h8000_0100);

      // redirect coincident with request handshake
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      tick();
      redirect_valid = 1'b0;
      settle();
      chk("rh_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rh_addr",      imem_req_addr, 64'h8000_0200);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0001;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("rh_id_valid",  {63'd0, id_valid}, 64'd0);
      chk("rh_req_valid2", {63'd0, imem_req_valid}, 64'd1);
      chk("rh_req_addr2", imem_req_addr, 64'h8000_0200);

      // fetch at target, then redirect in HOLD with id_ready high
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("f2_id_valid", {63'd0, id_valid}, 64'd1);
      chk("f2_id_inst",  {32'd0, id_inst}, 64'h0010_0093);
      chk("f2_id_pc",    id_pc, 64'h8000_0200);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; id_ready = 1'b1;
      settle();
      chk("rhold_id_valid", {63'd0, id_valid}, 64'd0);
      tick();
      redirect_valid = 1'b0; id_ready = 1'b0;
      settle();
      chk("rhold_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rhold_req_addr",  imem_req_addr, 64'h8000_0300);

      // redirect with response in WAIT: response dropped, kill stays clear
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0002;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
      tick();
      imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
      settle();
      chk("rwr_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rwr_req_addr",  imem_req_addr, 64'h8000_0400);
      chk("rwr_id_valid",  {63'd0, id_valid}, 64'd0);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0011;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("f3_id_valid", {63'd0, id_valid}, 64'd1);
      chk("f3_id_inst",  {32'd0, id_inst}, 64'h11);
      chk("f3_id_pc",    id_pc, 64'h8000_0400);

      // redirect in REQ while memory not ready
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0; imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0500;
      tick();
      redirect_valid = 1'b0;
      settle();
      chk("rnr_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rnr_req_addr",  imem_req_addr, 64'h8000_0500);
      tick();
      chk("rnr_still_req", {63'd0, imem_req_valid}, 64'd1);

      // PC wrap at top of address space
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0022;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr",  imem_req_addr, 64'd0);

      // stray response in HOLD ignored
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0003;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("stray_id_inst",  {32'd0, id_inst}, 64'h22);
      chk("stray_id_valid", {63'd0, id_valid}, 64'd1);

      // reset with a request outstanding; late response ignored
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      settle();
      chk("mrst_addr",    imem_req_addr, 64'h8000_0000);
      chk("mrst_id_inst", {32'd0, id_inst}, 64'd0);
      chk("mrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      tick();
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0004;
      tick();
      imem_rsp_valid = 1'b0;
      settle();
      chk("late_id_valid",  {63'd0, id_valid}, 64'd0);
      chk("late_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("late_req_addr",  imem_req_addr, 64'h8000_0000);
      tick();
      chk("late_wait_valid", {63'd0, imem_req_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22040931_ifu.md
Name: ysyx_22040931_ifu

Overview:
Instruction fetch unit. It owns the PC and issues one-outstanding requests to instruction memory. It presents fetched instructions to decode with a valid/ready handshake. It is the consumer of the branch-resolution "jump" result: it takes redirect_valid/redirect_pc from the branch/jump decode path, kills the in-flight or held wrong-path fetch, and restarts fetch at the target.

Parameters:
ADDR_W, 64, PC and memory address width (matches DATA_BUS width)
INST_W, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address (= pc)
imem_rsp_valid  in  1  response data valid (one-cycle pulse)
imem_rsp_data  in  INST_W  fetched instruction
redirect_valid  in  1  taken branch/jump resolved this cycle
redirect_pc  in  ADDR_W  redirect target
id_valid  out  1  instruction valid to decode
id_ready  in  1  decode accepts
id_inst  out  INST_W  instruction to decode
id_pc  out  ADDR_W  PC of id_inst
misalign_exc  out  1  only with YSYX_22040931_IFU_MISALIGN_EN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, req_pc=0, kill=0, id_inst=0, id_pc=0; every output reads 0 except imem_req_addr=RESET_PC.
- States IDLE, REQ, WAIT, HOLD. Outputs: imem_req_valid=(state==REQ); imem_req_addr=pc; id_valid=(state==HOLD)&&!redirect_valid.
- IDLE -> REQ unconditionally, so the first request is issued in the second cycle after rst_n rises.
- REQ: when valid&&ready, latch req_pc<=pc and go to WAIT.
- WAIT: rsp_valid with kill=1 -> drop the data, clear kill, go to REQ. rsp_valid with kill=0 -> id_inst<=rsp_data, id_pc<=req_pc, pc<=req_pc+4, go to HOLD.
- HOLD: id_valid&&id_ready -> go to REQ. Peak throughput is 1 instruction per 3 cycles with a zero-latency memory. This is intentional.
- pc+4 wraps modulo 2^ADDR_W.
- Redirect has the highest priority and is sampled in every non-IDLE state:
  - REQ with no handshake: pc<=redirect_pc; stay in REQ. The address may change while valid is high and unaccepted; the memory side allows this.
  - REQ with a handshake in the same cycle: pc<=redirect_pc, kill<=1, go to WAIT. The accepted request is wrong-path.
  - WAIT with rsp_valid in the same cycle: drop the response, pc<=redirect_pc, go to REQ.
  - WAIT without rsp_valid: pc<=redirect_pc, kill<=1, stay in WAIT.
  - HOLD: id_valid is forced low in the same cycle, so no transfer occurs even if id_ready=1. Set pc<=redirect_pc and go to REQ.
  - IDLE: pc<=redirect_pc.
- imem_rsp_valid outside WAIT is ignored.
- Reset mid-operation discards any outstanding request. A late response after reset is ignored because it arrives outside WAIT.
- The redirect target is used without alignment checks unless the optional feature is enabled.

Optional Feature:
- YSYX_22040931_IFU_MISALIGN_EN defined:
  - A misaligned redirect (redirect_valid && redirect_pc[1:0]!=0) leaves pc and state unchanged. It does not set kill or drop data.
  - misalign_exc is a registered one-cycle pulse in the next cycle. It resets to 0.
  - In HOLD, the combinational suppression of id_valid still applies.
- Undefined: the misalign_exc port is absent and all redirects follow the rules in Behaviour.

Decomposition:
- defines.v holds:
  - state encodings ysyx_22040931_IFU_IDLE/REQ/WAIT/HOLD (2 bits);
  - the RESET_PC constant ysyx_22040931_RESET_PC;
  - the INST_W width macro;
  - reuse of the existing DATA_BUS macro for ADDR_W.
- Sub-module: ysyx_22040931_pc_reg, a PC register with async active-low reset, next-PC select (hold / +4 / redirect) and the reset value as a parameter.

Test Plan:
- Reset release, imem_req_ready=1, rsp one cycle after handshake with data 32'h00000013 -> first req addr 0x80000000 at cycle 2; id_valid with id_pc=0x80000000 and id_inst=0x00000013; next req addr 0x80000004.
- id_ready held 0 for 5 cycles in HOLD -> id_valid and id_inst stable, imem_req_valid=0 throughout; id_ready=1 -> REQ next cycle.
- redirect_pc=0x80000100 while in WAIT, then rsp 0xDEADBEEF -> response discarded, id_valid never rises for it; next req addr 0x80000100.
- redirect in the same cycle as the REQ handshake, target 0x80000200 -> kill set; following rsp dropped; next request addr 0x80000200.
- redirect in HOLD with id_ready=1 -> id_valid=0 that cycle (no transfer); next req addr = redirect_pc.
- With MISALIGN_EN, redirect_pc=0x80000102 in REQ -> misalign_exc=1 for one cycle; req addr unchanged.
